mem_arbiter: RTL and testbench

Two-port memory arbiter that shares the single synchronous-read RAM between the CPU memory port (port 0) and a second bus master (port 1: loader/debug or DMA). It serialises requests, applies round-robin (or fixed) priority, sequences each RAM access through a 3-state FSM and returns read data with a one-cycle acknowledge. It sits between the CPU/second master and the RAM instance in the top level.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read RAM between two bus masters.
// Requests are serialised through IDLE -> ACCESS -> RESP. Each transaction
// returns a one-cycle ack and, for reads, a registered data word per port.
//
// Parameters:
//   AW  RAM address width (depth 2^AW words)
//   RR  1 = round-robin between ports, 0 = fixed priority (port 0 wins)
// Ports:
//   clk                   system clock, rising edge
//   reset                 asynchronous active-low reset
//   m0_cmd / m1_cmd       00 none, 01 read, 10 write, 11 none
//   m0_addr / m1_addr     word address; bit 8 set = unmapped
//   m0_wdata / m1_wdata   write data
//   m0_rdata / m1_rdata   registered read data per port
//   m0_ack / m1_ack       one-cycle completion pulse
//   busy                  high while not in IDLE
//   ram_addr/ram_din      RAM address / write data
//   ram_write             RAM write enable
//   ram_dout              RAM read data (one cycle after address)
module mem_arbiter #(
  parameter int unsigned AW = 8,
  parameter bit          RR = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    m0_cmd,
  input  logic [1:0]    m1_cmd,
  input  logic [8:0]    m0_addr,
  input  logic [8:0]    m1_addr,
  input  logic [15:0]   m0_wdata,
  input  logic [15:0]   m1_wdata,
  output logic [15:0]   m0_rdata,
  output logic [15:0]   m1_rdata,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic [15:0]   ram_din,
  output logic          ram_write,
  input  logic [15:0]   ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;   // 0 = port 0, 1 = port 1
  logic            wr_q, wr_d;         // latched cmd is a write
  logic            mapped_q, mapped_d;
  logic            last_q, last_d;     // port served most recently
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [15:0]     ram_din_q, ram_din_d;
  logic [15:0]     m0_rdata_q, m0_rdata_d;
  logic [15:0]     m1_rdata_q, m1_rdata_d;

  logic            req0, req1, pick1;
  logic [1:0]      sel_cmd;
  logic [8:0]      sel_addr;
  logic [15:0]     sel_wdata;
  logic [15:0]     rd_data;

  assign req0 = (m0_cmd == 2'b01) || (m0_cmd == 2'b10);
  assign req1 = (m1_cmd == 2'b01) || (m1_cmd == 2'b10);

  // The RAM address/data registers double as the latched request fields:
  // loaded on grant, so they drive the RAM during ACCESS and simply hold
  // their value in every other state.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    mapped_d   = mapped_q;
    last_d     = last_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    pick1      = 1'b0;
    sel_cmd    = m0_cmd;
    sel_addr   = m0_addr;
    sel_wdata  = m0_wdata;
    rd_data    = '0;

    if (req0 && req1) begin
      // last_q == 1 means port 1 was served last, so port 0 gets the turn
      pick1 = RR ? ~last_q : 1'b0;
    end else begin
      pick1 = req1;
    end

    if (pick1) begin
      sel_cmd   = m1_cmd;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d    = pick1;
          wr_d       = (sel_cmd == 2'b10);
          mapped_d   = ~sel_addr[8];
          ram_addr_d = sel_addr[AW-1:0];
          ram_din_d  = sel_wdata;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        if (!wr_q) begin
          rd_data = mapped_q ? ram_dout : '0;
          if (owner_q) m1_rdata_d = rd_data;
          else         m0_rdata_d = rd_data;
        end
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      mapped_q   <= 1'b0;
      last_q     <= 1'b1;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      mapped_q   <= mapped_d;
      last_q     <= last_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Decoded from state so that reset removes the write enable at once.
  assign ram_write = (state_q == ACCESS) && wr_q && mapped_q;
  assign m0_ack    = (state_q == RESP) && !owner_q;
  assign m1_ack    = (state_q == RESP) &&  owner_q;
  assign busy      = (state_q != IDLE);
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: one round-robin and one fixed-priority
// instance share the request inputs, each with its own RAM model. Expected
// acks (port, cycle, data) are queued when a request is driven and checked
// when the instance acknowledges.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  m0_cmd, m1_cmd;
  logic [8:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;

  logic [15:0] r1_m0_rdata, r1_m1_rdata, r0_m0_rdata, r0_m1_rdata;
  logic        r1_m0_ack, r1_m1_ack, r0_m0_ack, r0_m1_ack;
  logic        r1_busy, r0_busy;
  logic [7:0]  r1_ram_addr, r0_ram_addr;
  logic [15:0] r1_ram_din, r0_ram_din;
  logic        r1_ram_write, r0_ram_write;
  logic [15:0] r1_ram_dout, r0_ram_dout;

  logic [15:0] mem_r1 [256];
  logic [15:0] mem_r0 [256];

  typedef struct packed {
    logic        port;
    logic        rd;
    logic [15:0] data;
    logic [31:0] due;
  } exp_t;

  exp_t        q1[$];
  exp_t        q0[$];
  logic [15:0] mrd1 [2];
  logic [15:0] mrd0 [2];
  logic [15:0] ref_mem [256];
  int unsigned cyc;
  int          n_chk;
  int          n_fail;

  mem_arbiter #(.AW(8), .RR(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .m0_cmd(m0_cmd), .m1_cmd(m1_cmd),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_rdata(r1_m0_rdata), .m1_rdata(r1_m1_rdata),
    .m0_ack(r1_m0_ack), .m1_ack(r1_m1_ack),
    .busy(r1_busy),
    .ram_addr(r1_ram_addr), .ram_din(r1_ram_din),
    .ram_write(r1_ram_write), .ram_dout(r1_ram_dout)
  );

  mem_arbiter #(.AW(8), .RR(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .m0_cmd(m0_cmd), .m1_cmd(m1_cmd),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_rdata(r0_m0_rdata), .m1_rdata(r0_m1_rdata),
    .m0_ack(r0_m0_ack), .m1_ack(r0_m1_ack),
    .busy(r0_busy),
    .ram_addr(r0_ram_addr), .ram_din(r0_ram_din),
    .ram_write(r0_ram_write), .ram_dout(r0_ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM models
  always @(posedge clk) begin
    if (r1_ram_write) mem_r1[r1_ram_addr] <= r1_ram_din;
    r1_ram_dout <= mem_r1[r1_ram_addr];
  end

  always @(posedge clk) begin
    if (r0_ram_write) mem_r0[r0_ram_addr] <= r0_ram_din;
    r0_ram_dout <= mem_r0[r0_ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic svc(input bit rr);
    logic  a0, a1;
    int    qs;
    exp_t  e;
    string p;
    p  = rr ? "rr" : "fp";
    a0 = rr ? r1_m0_ack : r0_m0_ack;
    a1 = rr ? r1_m1_ack : r0_m1_ack;
    qs = rr ? q1.size() : q0.size();
    if (a0 || a1) begin
      chk({p, "_ack_exclusive"}, 32'(a0 & a1), 32'd0);
      chk({p, "_ack_expected"}, 32'(qs != 0), 32'd1);
      if (qs != 0) begin
        if (rr) e = q1.pop_front();
        else    e = q0.pop_front();
        chk({p, "_ack_port"}, 32'(a1), 32'(e.port));
        chk({p, "_ack_cycle"}, 32'(cyc), e.due);
        if (e.rd) begin
          if (rr) mrd1[e.port] = e.data;
          else    mrd0[e.port] = e.data;
        end
      end
    end else if (qs != 0) begin
      e = rr ? q1[0] : q0[0];
      if (32'(cyc) > e.due) begin
        chk({p, "_ack_missing"}, 32'(cyc), e.due);
        if (rr) void'(q1.pop_front());
        else    void'(q0.pop_front());
      end
    end
  endtask

  // Advance to the next falling edge, compare read data against the model,
  // then consume any acknowledge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("rr_m0_rdata", 32'(r1_m0_rdata), 32'(mrd1[0]));
    chk("rr_m1_rdata", 32'(r1_m1_rdata), 32'(mrd1[1]));
    chk("fp_m0_rdata", 32'(r0_m0_rdata), 32'(mrd0[0]));
    chk("fp_m1_rdata", 32'(r0_m1_rdata), 32'(mrd0[1]));
    svc(1'b1);
    svc(1'b0);
  endtask

  task automatic drive(input bit port, input logic [1:0] cmd,
                       input logic [8:0] addr, input logic [15:0] wd);
    if (port) begin
      m1_cmd = cmd; m1_addr = addr; m1_wdata = wd;
    end else begin
      m0_cmd = cmd; m0_addr = addr; m0_wdata = wd;
    end
  endtask

  function automatic exp_t mk(input bit port, input bit rd, input logic [8:0] addr,
                              input logic [31:0] due);
    exp_t e;
    e.port = port;
    e.rd   = rd;
    e.data = (rd && !addr[8]) ? ref_mem[addr[7:0]] : 16'h0000;
    e.due  = due;
    return e;
  endfunction

  // One isolated transaction on an idle arbiter, checked on both instances.
  task automatic xact(input bit port, input logic [1:0] cmd,
                      input logic [8:0] addr, input logic [15:0] wd);
    logic wr_map;
    exp_t e;
    wr_map = (cmd == 2'b10) && !addr[8];
    if (wr_map) ref_mem[addr[7:0]] = wd;
    e = mk(port, cmd == 2'b01, addr, 32'(cyc + 2));
    q1.push_back(e);
    q0.push_back(e);
    drive(port, cmd, addr, wd);
    tick();  // ACCESS
    chk("rr_ram_write_access", 32'(r1_ram_write), 32'(wr_map));
    chk("fp_ram_write_access", 32'(r0_ram_write), 32'(wr_map));
    chk("rr_busy_access", 32'(r1_busy), 32'd1);
    if (wr_map) begin
      chk("rr_ram_addr", 32'(r1_ram_addr), 32'(addr[7:0]));
      chk("fp_ram_addr", 32'(r0_ram_addr), 32'(addr[7:0]));
      chk("rr_ram_din", 32'(r1_ram_din), 32'(wd));
    end
    tick();  // RESP
    chk("rr_ram_write_resp", 32'(r1_ram_write), 32'd0);
    chk("fp_ram_write_resp", 32'(r0_ram_write), 32'd0);
    tick();  // IDLE
    chk("rr_busy_idle", 32'(r1_busy), 32'd0);
    drive(port, 2'b00, addr, wd);
  endtask

  task automatic chk_reset_outputs();
    chk("rr_rst_ram_write", 32'(r1_ram_write), 32'd0);
    chk("fp_rst_ram_write", 32'(r0_ram_write), 32'd0);
    chk("rr_rst_busy", 32'(r1_busy), 32'd0);
    chk("fp_rst_busy", 32'(r0_busy), 32'd0);
    chk("rr_rst_acks", 32'({r1_m0_ack, r1_m1_ack}), 32'd0);
    chk("fp_rst_acks", 32'({r0_m0_ack, r0_m1_ack}), 32'd0);
    chk("rr_rst_rdata", 32'({r1_m0_rdata, r1_m1_rdata}), 32'd0);
    chk("fp_rst_rdata", 32'({r0_m0_rdata, r0_m1_rdata}), 32'd0);
    chk("rr_rst_ram_addr", 32'(r1_ram_addr), 32'd0);
    chk("rr_rst_ram_din", 32'(r1_ram_din), 32'd0);
    chk("fp_rst_ram_addr", 32'(r0_ram_addr), 32'd0);
    chk("fp_rst_ram_din", 32'(r0_ram_din), 32'd0);
  endtask

  initial begin
    int unsigned k;
    n_chk = 0; n_fail = 0; cyc = 0;
    for (int unsigned i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    for (int unsigned i = 0; i < 2; i++) begin
      mrd1[i] = 16'h0000; mrd0[i] = 16'h0000;
    end
    reset = 1'b0;
    m0_cmd = 2'b00; m1_cmd = 2'b00;
    m0_addr = '0; m1_addr = '0;
    m0_wdata = '0; m1_wdata = '0;

    // Power-on reset
    tick();
    tick();
    chk_reset_outputs();
    reset = 1'b1;
    tick();

    // Preload RAM[5], then single read on port 0
    xact(1'b0, 2'b10, 9'h005, 16'h000C);
    xact(1'b0, 2'b01, 9'h005, 16'h0000);

    // Port 1 write then read back
    xact(1'b1, 2'b10, 9'h012, 16'hBEEF);
    xact(1'b1, 2'b01, 9'h012, 16'h0000);

    // Unmapped write and read on port 0
    xact(1'b0, 2'b10, 9'h140, 16'h5A5A);
    xact(1'b0, 2'b01, 9'h140, 16'h0000);

    // Reset asserted in the ACCESS cycle of a write
    drive(1'b1, 2'b10, 9'h012, 16'h1234);
    tick();
    chk("rr_ram_write_pre_abort", 32'(r1_ram_write), 32'd1);
    chk("fp_ram_write_pre_abort", 32'(r0_ram_write), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    for (int unsigned i = 0; i < 2; i++) begin
      mrd1[i] = 16'h0000; mrd0[i] = 16'h0000;
    end
    drive(1'b1, 2'b00, 9'h012, 16'h1234);
    tick();
    tick();
    reset = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      chk("rr_busy_after_reset", 32'(r1_busy), 32'd0);
      chk("fp_busy_after_reset", 32'(r0_busy), 32'd0);
    end

    // Contention: both ports read continuously
    k = cyc;
    drive(1'b0, 2'b01, 9'h005, 16'h0000);
    drive(1'b1, 2'b01, 9'h012, 16'h0000);
    q1.push_back(mk(1'b0, 1'b1, 9'h005, 32'(k + 2)));
    q1.push_back(mk(1'b1, 1'b1, 9'h012, 32'(k + 5)));
    q1.push_back(mk(1'b0, 1'b1, 9'h005, 32'(k + 8)));
    q1.push_back(mk(1'b1, 1'b1, 9'h012, 32'(k + 11)));
    q1.push_back(mk(1'b1, 1'b1, 9'h012, 32'(k + 14)));
    q0.push_back(mk(1'b0, 1'b1, 9'h005, 32'(k + 2)));
    q0.push_back(mk(1'b0, 1'b1, 9'h005, 32'(k + 5)));
    q0.push_back(mk(1'b0, 1'b1, 9'h005, 32'(k + 8)));
    q0.push_back(mk(1'b0, 1'b1, 9'h005, 32'(k + 11)));
    q0.push_back(mk(1'b1, 1'b1, 9'h012, 32'(k + 14)));
    for (int unsigned i = 0; i < 12; i++) tick();
    drive(1'b0, 2'b00, 9'h005, 16'h0000);
    for (int unsigned i = 0; i < 3; i++) tick();
    drive(1'b1, 2'b00, 9'h012, 16'h0000);
    for (int unsigned i = 0; i < 3; i++) tick();
    chk("rr_queue_drained", 32'(q1.size()), 32'd0);
    chk("fp_queue_drained", 32'(q0.size()), 32'd0);
    chk("rr_busy_end", 32'(r1_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
